// File: rtl/d_ff_pkg.sv
// Shared constants for the d_ff register family: parameter defaults and the
// legal ranges enforced when the register is elaborated.
package d_ff_pkg;
  localparam int D_FF_DEFAULT_WIDTH  = 1;
  localparam int D_FF_DEFAULT_STAGES = 1;
  localparam int D_FF_MIN_WIDTH      = 1;
  localparam int D_FF_MAX_WIDTH      = 1024;
  localparam int D_FF_MIN_STAGES     = 1;
  localparam int D_FF_MAX_STAGES     = 64;

  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction
endpackage

// File: rtl/d_ff_if.sv
// Data bundle for d_ff: the producer drives d and observes q, the register
// consumes d and drives q.
interface d_ff_if
  import d_ff_pkg::*;
#(
  parameter int WIDTH = D_FF_DEFAULT_WIDTH
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input q);
  modport slave  (input d, output q);
endinterface

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register with synchronous active-high reset to RESET_VAL;
// the building block chained by d_ff to form a delay line.
module d_ff_stage
  import d_ff_pkg::*;
#(
  parameter int               WIDTH     = D_FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // reset_n is active-high despite its name; reset wins over data
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/d_ff.sv
// Parameterizable D register / delay line: STAGES cascaded WIDTH-bit stages,
// q is the last stage register with no combinational path from the inputs.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int               WIDTH     = D_FF_DEFAULT_WIDTH,
  parameter int               STAGES    = D_FF_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic   clk,
  input  logic   reset_n,
  d_ff_if.slave  bus
);
  generate
    if (!in_range(WIDTH, D_FF_MIN_WIDTH, D_FF_MAX_WIDTH)) begin : g_bad_width
      $fatal(1, "d_ff: WIDTH=%0d outside legal range", WIDTH);
    end
    if (!in_range(STAGES, D_FF_MIN_STAGES, D_FF_MAX_STAGES)) begin : g_bad_stages
      $fatal(1, "d_ff: STAGES=%0d outside legal range", STAGES);
    end
  endgenerate

  logic [WIDTH-1:0] w_chain [STAGES+1];

  assign w_chain[0] = bus.d;

  // A single shared reset clears every stage on the same edge, so no
  // in-flight data survives a reset.
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      d_ff_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (w_chain[g]),
        .o_q     (w_chain[g+1])
      );
    end
  endgenerate

  assign bus.q = w_chain[STAGES];
endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: three configurations driven together with
// directed and random stimulus, compared against a sample-history model.
module tb_d_ff;
  import d_ff_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst8, rst32;

  d_ff_if #(.WIDTH(1))  bus1 ();
  d_ff_if #(.WIDTH(8))  bus8 ();
  d_ff_if #(.WIDTH(32)) bus32 ();

  d_ff #(.WIDTH(1), .STAGES(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .reset_n(rst1), .bus(bus1));
  d_ff #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .reset_n(rst8), .bus(bus8));
  d_ff #(.WIDTH(32), .STAGES(1), .RESET_VAL(32'h0000_0000)) dut32 (
    .clk(clk), .reset_n(rst32), .bus(bus32));

  int checks   = 0;
  int failures = 0;

  // History of sampled {reset, data} per edge, newest at the back.
  logic [32:0] h1[$];
  logic [32:0] h8[$];
  logic [32:0] h32[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // q after the latest edge: data sampled s-1 edges ago, unless any of the
  // last s edges saw reset, in which case the reset value.
  function automatic logic [31:0] model_q(input logic [32:0] h[$], input int s,
                                          input logic [31:0] rv);
    int n;
    n = h.size();
    for (int k = 0; k < s; k++) begin
      if (n - 1 - k < 0) return rv;
      if (h[n-1-k][32]) return rv;
    end
    return h[n-s][31:0];
  endfunction

  // Called at a negedge: glitch inputs off-edge, settle real values, let one
  // posedge pass, then compare at the following negedge.
  task automatic step(input logic r1, input logic d1, input logic r8, input logic [7:0] d8,
                      input logic r32, input logic [31:0] d32);
    logic [31:0] rnd;
    rnd = $urandom;
    rst1 = 1'b1; rst8 = 1'b1; rst32 = 1'b1;
    bus1.d = rnd[0]; bus8.d = rnd[15:8]; bus32.d = ~rnd;
    #2;
    rst1 = r1; bus1.d = d1;
    rst8 = r8; bus8.d = d8;
    rst32 = r32; bus32.d = d32;
    h1.push_back({r1, 31'd0, d1});
    h8.push_back({r8, 24'd0, d8});
    h32.push_back({r32, d32});
    if (h1.size() > 80) void'(h1.pop_front());
    if (h8.size() > 80) void'(h8.pop_front());
    if (h32.size() > 80) void'(h32.pop_front());
    @(negedge clk);
    check_val("model_q1",  {31'd0, bus1.q}, model_q(h1, 1, 32'h0000_0000));
    check_val("model_q8",  {24'd0, bus8.q}, model_q(h8, 3, 32'h0000_00A5));
    check_val("model_q32", bus32.q,         model_q(h32, 1, 32'h0000_0000));
  endtask

  logic [6:0]  seq2;
  logic [7:0]  exp4 [5];
  logic [31:0] vals6 [3];
  logic [31:0] r;

  initial begin
    seq2     = 7'b1011011;
    exp4[0] = 8'hA5; exp4[1] = 8'hA5; exp4[2] = 8'h01; exp4[3] = 8'h02; exp4[4] = 8'h03;
    vals6[0] = 32'hDEAD_BEEF; vals6[1] = 32'h0000_0000; vals6[2] = 32'hFFFF_FFFF;
    rst1 = 1'b0; rst8 = 1'b0; rst32 = 1'b0;
    bus1.d = 1'b0; bus8.d = 8'h00; bus32.d = 32'h0;
    @(negedge clk);

    // Reset and capture
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h1234_5678);
    check_val("t1_reset_q1",  {31'd0, bus1.q}, 32'h0);
    check_val("t1_reset_q8",  {24'd0, bus8.q}, 32'hA5);
    check_val("t1_reset_q32", bus32.q, 32'h0);
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 32'h1234_5678);
    check_val("t1_capture", {31'd0, bus1.q}, 32'h1);

    // Data tracking, every cycle has off-edge glitches and reset pulses
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, seq2[i], 1'b1, 8'h00, 1'b0, 32'h0);
      check_val("t2_track", {31'd0, bus1.q}, {31'd0, seq2[i]});
    end

    // Reset priority over d
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 32'hFFFF_FFFF);
    check_val("t3_priority", {31'd0, bus1.q}, 32'h0);

    // Multi-stage latency: reset (above) then 01..05
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      step(1'b0, r[0], 1'b0, 8'(i + 1), 1'b0, r);
      check_val("t4_latency", {24'd0, bus8.q}, {24'd0, exp4[i]});
    end

    // Mid-stream reset flushes 10,11,12 in one edge
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      step(1'b0, r[0], 1'b0, 8'(8'h10 + i), 1'b0, r);
    end
    check_val("t5_prefill", {24'd0, bus8.q}, 32'h10);
    step(1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 32'h0);
    check_val("t5_flush0", {24'd0, bus8.q}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      step(1'b0, r[0], 1'b0, 8'(8'h20 + i), 1'b0, r);
      check_val("t5_flush", {24'd0, bus8.q}, (i < 2) ? 32'hA5 : 32'h20);
    end

    // Wide bus bit integrity
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, vals6[i]);
      check_val("t6_wide", bus32.q, vals6[i]);
    end

    // Random traffic with occasional resets on each instance
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      step(a[31:28] == 4'd0, a[0], b[31:28] == 4'd0, b[7:0], c[31:28] == 4'd0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/d_ff.md
Name: d_ff

Overview:
- Parameterizable positive-edge D-type register: samples `d` on every rising `clk` edge and presents it on `q`.
- Basic storage primitive for the design's sequential logic; used directly as a single-bit flip-flop (default) or as a multi-bit, multi-stage register/delay line.
- Single clock domain, synchronous active-high reset, no enable.

Parameters:
- WIDTH, 1, bit width of `d` and `q`; legal range 1..1024.
- STAGES, 1, number of cascaded register stages between `d` and `q`; legal range 1..64; sets latency in clock cycles.
- RESET_VAL, 0 (WIDTH bits), value loaded into every stage on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge only.
- reset_n  input  1  synchronous reset, active-high. The name is the codebase's standard reset port name; 1 = reset asserted, 0 = normal operation.
- d  input  WIDTH  data input, sampled on the rising `clk` edge.
- q  output  WIDTH  registered data output; driven directly by the last stage register, with no combinational path from `d` or `reset_n`.

Behaviour:
- All state changes occur only on the rising edge of `clk`. There is no asynchronous path.
- Reset:
  - If `reset_n`=1 at a rising edge, every stage loads RESET_VAL, so `q`=RESET_VAL after that edge.
  - Reset takes priority over `d`.
  - Asserting or deasserting `reset_n` between edges has no effect until the next rising edge.
- Normal operation, `reset_n`=0 at a rising edge:
  - stage[0] <= d.
  - stage[i] <= stage[i-1] for i = 1..STAGES-1.
  - q = stage[STAGES-1].
- Latency:
  - `q` reflects the `d` sampled STAGES rising edges earlier.
  - With STAGES=1, `q` updates on the same edge that samples `d` and is stable for the full following cycle.
- After reset release, `q` stays RESET_VAL for STAGES-1 further edges. The pipeline then fills in order, with no stale pre-reset data.
- Reset mid-operation clears all in-flight data in one edge. No partial flush.
- Power-up, before the first reset edge: `q` is unspecified (X in simulation). No initial-value reliance is permitted.
- `d` changes not coincident with a rising edge are ignored. Glitches between edges never propagate.
- Width: pure bit-copy, no arithmetic, no sign handling. RESET_VAL is truncated or zero-extended to WIDTH.
- Parameter checks: elaboration fails if WIDTH<1 or STAGES<1.

Decomposition:
- Shared package `d_ff_pkg`:
  - constants D_FF_DEFAULT_WIDTH=1 and D_FF_DEFAULT_STAGES=1;
  - the legal-range limits used by the elaboration checks.
- One natural sub-module, `d_ff_stage`:
  - a single WIDTH-bit register with synchronous active-high reset to RESET_VAL;
  - instantiated STAGES times in a generate loop, chained `d` -> stage[0] -> ... -> `q`.
- Parameter-legality assertions and the optional simulation-only output-X checker live in the top module.

Test Plan:
1. Reset and capture, WIDTH=1, STAGES=1: `reset_n`=1 for one edge with `d`=0 -> `q`=0. Deassert with `d`=1, one edge -> `q`=1.
2. Data tracking, WIDTH=1, STAGES=1: drive `d` = 1,1,0,1,1,0,1 on successive edges with reset low -> after each edge `q` equals the `d` just sampled. Mid-cycle `d` toggles do not change `q`.
3. Reset priority: `d`=1 and `reset_n`=1 on the same edge -> `q`=0. `reset_n` pulsed high between edges only (not at an edge) -> `q` unchanged.
4. Multi-stage latency, WIDTH=8, STAGES=3, RESET_VAL=8'hA5: reset, then `d`=8'h01,8'h02,8'h03,8'h04 -> `q`=A5,A5,01,02,03 on edges 1..5 after release. Exactly 3-cycle latency.
5. Mid-stream reset, WIDTH=8, STAGES=3: with 8'h10,8'h11,8'h12 in flight, assert reset for one edge -> `q`=RESET_VAL on that edge and the next two. No in-flight values ever appear on `q`.
6. Wide bus, WIDTH=32, STAGES=1: `d`=32'hDEADBEEF then 32'h00000000 then 32'hFFFFFFFF -> `q` matches each value one edge later, with no bit slipping.
